// File: rtl/s_uart_rx.sv
// 8N1 UART receiver with oversampled tick, majority-style input filter and framing-error strobe.
// Optional line-idle / end-of-packet detection is built when S_UART_RX_IDLE_DETECT_EN is defined.
`timescale 1ns/1ps
module s_uart_rx #(
  parameter int ClkFrequency = 10000000,
  parameter int Baud         = 500000,
  parameter int Oversampling = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_busy,
  output logic       RxD_idle,
  output logic       RxD_endofpacket
);

  localparam int AccW  = 24;
  localparam int SampW = $clog2(Oversampling);
  localparam longint unsigned TickRate = longint'(Baud) * longint'(Oversampling);
  localparam longint unsigned IncL =
    ((TickRate << AccW) + longint'(ClkFrequency) / 2) / longint'(ClkFrequency);
  localparam logic [AccW:0]      Inc     = IncL[AccW:0];
  localparam logic [SampW-1:0]   SampMid = SampW'(Oversampling / 2 - 1);

  generate
    if (Oversampling < 4 || (Oversampling & (Oversampling - 1)) != 0) begin : g_bad_os
      $error("s_uart_rx: Oversampling must be a power of 2 and >= 4");
    end
    if (longint'(ClkFrequency) < TickRate) begin : g_bad_clk
      $error("s_uart_rx: ClkFrequency must be >= Baud*Oversampling");
    end
  endgenerate

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    BIT0      = 4'd2,
    BIT1      = 4'd3,
    BIT2      = 4'd4,
    BIT3      = 4'd5,
    BIT4      = 4'd6,
    BIT5      = 4'd7,
    BIT6      = 4'd8,
    BIT7      = 4'd9,
    STOP      = 4'd10,
    WAIT_HIGH = 4'd11
  } state_e;

  logic [AccW-1:0]  acc_q, acc_d;
  logic             tick;
  logic             rxd_meta_q, rxd_sync_q;
  logic [1:0]       filt_cnt_q, filt_cnt_d;
  logic             filt_q, filt_d;
  logic [SampW-1:0] samp_q, samp_d;
  logic             start_det, sample_pt;
  state_e           state_q;
  logic [7:0]       shift_q, data_q;
  logic             ready_q, ferr_q, busy_q;

  // Tick is the carry out of a free-running phase accumulator.
  assign {tick, acc_d} = {1'b0, acc_q} + Inc;

  // The filtered bit follows the updated count so a fresh reset (count 0, bit high) does not fake a start.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    filt_d     = filt_q;
    if (tick) begin
      if (rxd_sync_q && filt_cnt_q != 2'd3)
        filt_cnt_d = filt_cnt_q + 2'd1;
      else if (!rxd_sync_q && filt_cnt_q != 2'd0)
        filt_cnt_d = filt_cnt_q - 2'd1;
      if (filt_cnt_d == 2'd3)
        filt_d = 1'b1;
      else if (filt_cnt_d == 2'd0)
        filt_d = 1'b0;
    end
  end

  assign start_det = tick && (state_q == IDLE) && !filt_q;
  assign sample_pt = tick && (samp_q == SampMid);

  always_comb begin
    samp_d = samp_q;
    if (start_det)
      samp_d = '0;
    else if (tick)
      samp_d = samp_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      filt_cnt_q <= 2'd0;
      filt_q     <= 1'b1;
      samp_q     <= '0;
    end else begin
      acc_q      <= acc_d;
      rxd_meta_q <= RxD;
      rxd_sync_q <= rxd_meta_q;
      filt_cnt_q <= filt_cnt_d;
      filt_q     <= filt_d;
      samp_q     <= samp_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_det) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (sample_pt) begin
            if (filt_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= BIT0;
            end
          end
        end
        BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
          if (sample_pt) begin
            shift_q <= {filt_q, shift_q[7:1]};
            state_q <= state_e'(state_q + 4'd1);
          end
        end
        STOP: begin
          if (sample_pt) begin
            busy_q <= 1'b0;
            if (filt_q) begin
              data_q  <= shift_q;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (tick && filt_q)
            state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign RxD_data       = data_q;
  assign RxD_data_ready = ready_q;
  assign RxD_frame_err  = ferr_q;
  assign RxD_busy       = busy_q;

`ifdef S_UART_RX_IDLE_DETECT_EN
  localparam int GapMax = 10 * Oversampling;
  localparam int GapW   = $clog2(GapMax + 1);
  localparam logic [GapW-1:0] GapMaxV = GapW'(GapMax);

  logic [GapW-1:0] gap_q, gap_d;
  logic            idle_q, idle_d, got_byte_q, eop_q, eop_fire;

  always_comb begin
    gap_d = gap_q;
    if (start_det)
      gap_d = '0;
    else if (tick && state_q == IDLE && filt_q && gap_q != GapMaxV)
      gap_d = gap_q + 1'b1;
  end

  assign idle_d   = (gap_d == GapMaxV);
  assign eop_fire = idle_d && !idle_q && got_byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q      <= '0;
      idle_q     <= 1'b0;
      got_byte_q <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      gap_q  <= gap_d;
      idle_q <= idle_d;
      eop_q  <= eop_fire;
      if (eop_fire)
        got_byte_q <= 1'b0;
      else if (ready_q)
        got_byte_q <= 1'b1;
    end
  end

  assign RxD_idle        = idle_q;
  assign RxD_endofpacket = eop_q;
`else
  assign RxD_idle        = 1'b0;
  assign RxD_endofpacket = 1'b0;
`endif

endmodule
